// File: rtl/img_pattern_gen_if.sv
// img_pattern_gen_if: sensor-side pixel bus (frame valid, line valid, 12-bit pixel data).
interface img_pattern_gen_if;
   logic        fv;
   logic        lv;
   logic [11:0] d;
   modport master (output fv, lv, d);
   modport slave  (input fv, lv, d);
endinterface

// File: rtl/img_pattern_gen.sv
// img_pattern_gen: synthetic image-sensor transmitter with configurable frame timing and test patterns.
// Define IMG_PATTERN_LFSR_EN to make pattern 3 a 12-bit Galois LFSR; otherwise pattern 3 equals pattern 0.
module img_pattern_gen #(
   parameter int ImgWidth      = 2304,
   parameter int ImgHeight     = 1296,
   parameter int HBlankCycles  = 16,
   parameter int VBlankCycles  = 64,
   parameter int FvLeadCycles  = 4,
   parameter int FvTrailCycles = 4
) (
   input  logic              clk,
   input  logic              rst_,
   input  logic              cmd_start,
   input  logic              cmd_stop,
   input  logic [7:0]        cmd_frameCount,
   input  logic [1:0]        cmd_pattern,
   input  logic [11:0]       cmd_seed,
   img_pattern_gen_if.master img,
   output logic              status_busy,
   output logic              status_frameDone,
   output logic [7:0]        status_frameIndex
);
   localparam int XW = (ImgWidth > 1) ? $clog2(ImgWidth) : 1;
   localparam int YW = (ImgHeight > 1) ? $clog2(ImgHeight) : 1;
   localparam int M1 = (ImgWidth > HBlankCycles) ? ImgWidth : HBlankCycles;
   localparam int M2 = (M1 > VBlankCycles) ? M1 : VBlankCycles;
   localparam int M3 = (M2 > FvLeadCycles) ? M2 : FvLeadCycles;
   localparam int M4 = (M3 > FvTrailCycles) ? M3 : FvTrailCycles;
   localparam int CW = $clog2(M4 + 1);

   typedef enum logic [2:0] {IDLE, LEAD, LINE, HBLANK, TRAIL, VBLANK} state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d, len_m1;
   logic [XW-1:0]  x_q, x_d;
   logic [YW-1:0]  y_q, y_d;
   logic [7:0]     fc_q, fc_d, idx_q, idx_d;
   logic [1:0]     pat_q, pat_d;
   logic [11:0]    seed_q, seed_d, d_q, d_d, pix, pat3;
   logic           armed_q, start_trk_q, stop_trk_q, stop_pend_q, stop_pend_d;
   logic           busy_q, busy_d, done_q, done_d, fv_q, fv_d, lv_q, lv_d;
   logic           start_tg, stop_tg, last;
`ifdef IMG_PATTERN_LFSR_EN
   logic [11:0]    lfsr_q, lfsr_d;
`endif

   always_comb begin
      start_tg = armed_q & (cmd_start ^ start_trk_q);
      stop_tg  = armed_q & (cmd_stop ^ stop_trk_q);
      len_m1   = state_q == LEAD   ? CW'(FvLeadCycles - 1)  :
                 state_q == LINE   ? CW'(ImgWidth - 1)      :
                 state_q == HBLANK ? CW'(HBlankCycles - 1)  :
                 state_q == TRAIL  ? CW'(FvTrailCycles - 1) : CW'(VBlankCycles - 1);
      last     = cnt_q == len_m1;
      state_d  = state_q;
      fc_d     = fc_q;
      pat_d    = pat_q;
      seed_d   = seed_q;
      idx_d    = idx_q;
      done_d   = done_q;
      stop_pend_d = stop_pend_q | (busy_q & stop_tg);
      case (state_q)
         IDLE: if (start_tg) begin
            state_d     = LEAD;
            fc_d        = cmd_frameCount;
            pat_d       = cmd_pattern;
            seed_d      = cmd_seed;
            idx_d       = '0;
            stop_pend_d = stop_tg;
         end
         LEAD:   if (last) state_d = LINE;
         LINE:   if (last) state_d = (y_q == YW'(ImgHeight - 1)) ? TRAIL : HBLANK;
         HBLANK: if (last) state_d = LINE;
         TRAIL: if (last) begin
            done_d  = ~done_q;
            idx_d   = idx_q + 8'd1;
            state_d = (stop_pend_q | stop_tg | (fc_q != 8'd0 && idx_q + 8'd1 == fc_q)) ? IDLE : VBLANK;
         end
         VBLANK: if (last) state_d = LEAD;
         default: state_d = IDLE;
      endcase
      if (state_d == IDLE) stop_pend_d = 1'b0;
      busy_d = state_d != IDLE;
      cnt_d  = (state_d == state_q) ? cnt_q + CW'(1) : '0;
      // x/y/lfsr always describe the pixel that is on the bus while state is LINE
      x_d    = (state_q == LINE && state_d == LINE) ? x_q + XW'(1) : '0;
      y_d    = state_q == LEAD ? '0 : (state_q == LINE && state_d == HBLANK) ? y_q + YW'(1) : y_q;
`ifdef IMG_PATTERN_LFSR_EN
      lfsr_d = state_q == LEAD ? ((seed_q == 12'd0) ? 12'h001 : seed_q) :
               state_q == LINE ? ({1'b0, lfsr_q[11:1]} ^ (lfsr_q[0] ? 12'h829 : 12'h000)) : lfsr_q;
      pat3   = lfsr_d;
`else
      pat3   = seed_q;
`endif
      pix  = pat_q == 2'd1 ? seed_q + 12'(x_d) :
             pat_q == 2'd2 ? ((x_d[0] ^ y_d[0]) ? 12'h000 : 12'hFFF) :
             pat_q == 2'd3 ? pat3 : seed_q;
      fv_d = state_d inside {LEAD, LINE, HBLANK, TRAIL};
      lv_d = state_d == LINE;
      d_d  = lv_d ? pix : 12'h000;
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         x_q         <= '0;
         y_q         <= '0;
         fc_q        <= '0;
         pat_q       <= '0;
         seed_q      <= '0;
         idx_q       <= '0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         stop_pend_q <= 1'b0;
         armed_q     <= 1'b0;
         start_trk_q <= 1'b0;
         stop_trk_q  <= 1'b0;
         fv_q        <= 1'b0;
         lv_q        <= 1'b0;
         d_q         <= '0;
`ifdef IMG_PATTERN_LFSR_EN
         lfsr_q      <= 12'h001;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         x_q         <= x_d;
         y_q         <= y_d;
         fc_q        <= fc_d;
         pat_q       <= pat_d;
         seed_q      <= seed_d;
         idx_q       <= idx_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
         stop_pend_q <= stop_pend_d;
         armed_q     <= 1'b1;
         start_trk_q <= cmd_start;
         stop_trk_q  <= cmd_stop;
         fv_q        <= fv_d;
         lv_q        <= lv_d;
         d_q         <= d_d;
`ifdef IMG_PATTERN_LFSR_EN
         lfsr_q      <= lfsr_d;
`endif
      end
   end

   assign img.fv            = fv_q;
   assign img.lv            = lv_q;
   assign img.d             = d_q;
   assign status_busy       = busy_q;
   assign status_frameDone  = done_q;
   assign status_frameIndex = idx_q;
endmodule

// File: tb/tb_img_pattern_gen.sv
// tb_img_pattern_gen: randomized runs of img_pattern_gen checked by a pixel/frame scoreboard.
module tb_img_pattern_gen;
   localparam int W = 8, H = 4, HB = 2, VB = 3, LEAD = 2, TRAIL = 2;
   localparam int FV_LEN = LEAD + H * W + (H - 1) * HB + TRAIL;
`ifdef IMG_PATTERN_LFSR_EN
   localparam bit LFSR_EN = 1'b1;
`else
   localparam bit LFSR_EN = 1'b0;
`endif

   logic        clk = 1'b0, rst_ = 1'b0, cmd_start = 1'b0, cmd_stop = 1'b0;
   logic [7:0]  cmd_frameCount = '0;
   logic [1:0]  cmd_pattern = '0;
   logic [11:0] cmd_seed = '0;
   logic        status_busy, status_frameDone;
   logic [7:0]  status_frameIndex;

   img_pattern_gen_if img();

   img_pattern_gen #(
      .ImgWidth(W), .ImgHeight(H), .HBlankCycles(HB), .VBlankCycles(VB),
      .FvLeadCycles(LEAD), .FvTrailCycles(TRAIL)
   ) dut (
      .clk(clk), .rst_(rst_), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
      .cmd_frameCount(cmd_frameCount), .cmd_pattern(cmd_pattern), .cmd_seed(cmd_seed),
      .img(img), .status_busy(status_busy), .status_frameDone(status_frameDone),
      .status_frameIndex(status_frameIndex)
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_fail = 0, done_cnt = 0;
   int pix_q[$];
   int len_q[$];

   task automatic chk(string nm, int act, int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // reference model: every frame is the full raster of pattern values, reseeded per frame
   task automatic push_frames(int pat, int seed, int n);
      for (int f = 0; f < n; f++) begin
         int l = (seed == 0) ? 1 : seed;
         len_q.push_back(FV_LEN);
         for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
               int p;
               if (pat == 1) p = (x + seed) % 4096;
               else if (pat == 2) p = ((x + y) % 2 == 1) ? 0 : 4095;
               else if (pat == 3 && LFSR_EN) p = l;
               else p = seed;
               pix_q.push_back(p);
               l = (l % 2 == 1) ? ((l / 2) ^ 'h829) : (l / 2);
            end
      end
   endtask

   logic prev_fv = 1'b0, prev_lv = 1'b0, prev_done = 1'b0;
   bit   gap_valid = 1'b0;
   int   fv_len = 0, gap = 0, lv_low = 0, line_no = 0;

   always @(negedge clk) begin
      if (!rst_) begin
         pix_q.delete();
         len_q.delete();
         prev_fv = 1'b0; prev_lv = 1'b0; prev_done = 1'b0; gap_valid = 1'b0;
      end else begin
         if (img.lv) begin
            chk("lv_in_fv", int'(img.fv), 1);
            if (pix_q.size() == 0) chk("unexpected_pixel", int'(img.d), -1);
            else chk("pixel", int'(img.d), pix_q.pop_front());
         end else chk("d_idle", int'(img.d), 0);
         if (img.fv && !prev_fv) begin
            if (gap_valid) chk("vblank_gap", gap, VB);
            fv_len = 0; line_no = 0; lv_low = 0;
         end
         if (img.fv) fv_len++;
         if (img.fv && !img.lv) lv_low++;
         if (img.lv && !prev_lv) begin
            chk("lv_low_before_line", lv_low, (line_no == 0) ? LEAD : HB);
            line_no++;
         end
         if (img.lv) lv_low = 0;
         if (!img.fv && prev_fv) begin
            chk("trail", lv_low, TRAIL);
            chk("lines", line_no, H);
            if (len_q.size() == 0) chk("unexpected_frame", fv_len, -1);
            else chk("fv_len", fv_len, len_q.pop_front());
            gap = 0;
            gap_valid = status_busy;
         end
         if (!img.fv) gap++;
         if (status_frameDone != prev_done) begin
            done_cnt++;
            chk("done_at_fv_fall", int'(prev_fv && !img.fv), 1);
         end
         prev_fv = img.fv; prev_lv = img.lv; prev_done = status_frameDone;
      end
   end

   task automatic run(int pat, int seed, int fc, int nexp, bit stop_at1, bit both, bit restart);
      int d0 = done_cnt;
      cmd_pattern = 2'(pat); cmd_seed = 12'(seed); cmd_frameCount = 8'(fc);
      push_frames(pat, seed, nexp);
      cmd_start = ~cmd_start;
      if (both) cmd_stop = ~cmd_stop;
      tick(1);
      chk("busy_rise", int'(status_busy), 1);
      chk("index_clear", int'(status_frameIndex), 0);
      cmd_pattern = 2'($urandom); cmd_seed = 12'($urandom); cmd_frameCount = 8'($urandom);
      if (restart) begin
         tick(20);
         cmd_start = ~cmd_start;
      end
      if (stop_at1) begin
         for (int i = 0; i < 2000 && status_frameIndex != 8'd1; i++) tick(1);
         chk("reach_index1", int'(status_frameIndex), 1);
         tick(10);
         cmd_stop = ~cmd_stop;
      end
      for (int i = 0; i < 20000 && status_busy; i++) tick(1);
      chk("busy_fall", int'(status_busy), 0);
      chk("frame_index", int'(status_frameIndex), nexp);
      tick(10);
      chk("done_toggles", done_cnt - d0, nexp);
      chk("queue_drained", pix_q.size(), 0);
      chk("fv_idle", int'(img.fv), 0);
   endtask

   initial begin
      cmd_start = 1'b1;
      tick(5);
      rst_ = 1'b1;
      tick(100);
      chk("reset_fv", int'(img.fv), 0);
      chk("reset_lv", int'(img.lv), 0);
      chk("reset_d", int'(img.d), 0);
      chk("reset_busy", int'(status_busy), 0);
      chk("reset_done", int'(status_frameDone), 0);
      chk("reset_index", int'(status_frameIndex), 0);
      run(1, 0, 1, 1, 0, 0, 0);
      for (int k = 0; k < 6; k++) begin
         int fc = $urandom_range(1, 3);
         run($urandom_range(0, 3), $urandom_range(0, 4095), fc, fc, 0, 0, k == 2);
      end
      run(3, 0, 2, 2, 0, 0, 0);
      run(3, 'h5A5, 1, 1, 0, 0, 0);
      run($urandom_range(0, 3), $urandom_range(0, 4095), 0, 2, 1, 0, 0);
      run(1, 7, 0, 1, 0, 1, 0);
      cmd_stop = ~cmd_stop;
      tick(5);
      chk("stop_in_idle", int'(status_busy), 0);
      run(2, $urandom_range(0, 4095), 2, 2, 0, 0, 0);
      cmd_pattern = 2'd1; cmd_seed = 12'h123; cmd_frameCount = 8'd1;
      push_frames(1, 'h123, 1);
      cmd_start = ~cmd_start;
      for (int i = 0; i < 200 && !img.lv; i++) tick(1);
      chk("reached_line", int'(img.lv), 1);
      chk("line_data", int'(img.d), 'h123);
      #2 rst_ = 1'b0;
      #1;
      chk("rst_fv", int'(img.fv), 0);
      chk("rst_lv", int'(img.lv), 0);
      chk("rst_d", int'(img.d), 0);
      chk("rst_busy", int'(status_busy), 0);
      tick(3);
      rst_ = 1'b1;
      tick(60);
      chk("post_rst_busy", int'(status_busy), 0);
      chk("post_rst_fv", int'(img.fv), 0);
      run(2, 'h0F0, 1, 1, 0, 0, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
